mfp_uart_tx: RTL
================

# mfp_uart_tx

Buffered 8N1 UART transmitter, the transmit counterpart of the system's `UART_RX` receive path. It accepts bytes over a valid/ready handshake into a small FIFO and serializes them LSB-first onto a single line at a fixed baud rate. It sits beside the receiver inside the I/O subsystem and drives the board's UART RX pin (`UART_RXD_OUT`) at the top level.

## Interface
- `CLK_HZ`, default 50_000_000: `HCLK` frequency in Hz.
- `BAUD`, default 115200: line rate. Bit period `DIV = (CLK_HZ + BAUD/2) / BAUD`, which is 434 at the defaults. `DIV` must be ≥ 2.
- `FIFO_DEPTH`, default 4: byte FIFO depth. Must be a power of 2 and ≥ 2.
- `HCLK` in, 1: system clock. All logic is on the rising edge.
- `HRESET` in, 1: asynchronous, active-high reset.
- `tx_data` in, 8: byte to send.
- `tx_valid` in, 1: producer offers `tx_data`.
- `tx_ready` out, 1: FIFO not full. Reset value 1.
- `UART_TX` out, 1: serial line, idle high, registered. Reset value 1.
- `busy` out, 1: high when the FSM is not IDLE or the FIFO is non-empty. Reset value 0.
- `fifo_count` out, `$clog2(FIFO_DEPTH+1)`: number of bytes queued, excluding the byte being shifted. Reset value 0.

## Operation
- **Push.** A byte is pushed on any rising edge where `tx_valid && tx_ready`.
- **`tx_ready`.** Equals `fifo_count != FIFO_DEPTH` and is derived only from the registered count. A pop in the same cycle does not raise `tx_ready`.
- **Push and pop together.** If both happen on one edge, `fifo_count` is unchanged and both actions take effect.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `UART_TX`=1. If the FIFO is non-empty: pop into the shift register, clear the baud counter, go to START.
  - START: `UART_TX`=0 for `DIV` cycles, then go to DATA with bit index 0.
  - DATA: `UART_TX`=`shift[0]` for `DIV` cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `UART_TX`=1 for `DIV` cycles. On the final cycle, if the FIFO is non-empty, pop and go straight to START (back-to-back frames with no idle gap). Otherwise go to IDLE.
- **Baud counter.** Counts 0..`DIV`-1 and wraps. A state or bit advances on the edge where the counter equals `DIV`-1.
- **Data integrity.** Pushes during a frame never disturb the byte being shifted.
- **Pushing while full.** Ignored with no side effects; the producer must hold `tx_valid`.
- **`HRESET` mid-frame.**
  - `UART_TX` goes to 1 immediately, without waiting for a clock.
  - The FIFO is flushed and the FSM returns to IDLE.
  - The partial frame is abandoned; the receiver sees a truncated frame with no stop bit, which is accepted behaviour.

## Timing
- **Latency.** A byte pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. `UART_TX` falls after edge N+2, because the START output is registered.
- **Frame length.** Exactly `10*DIV` cycles. Back-to-back frames start exactly `10*DIV` cycles apart.
- **Bit order.** Start bit, then `tx_data[0]` through `tx_data[7]`, then stop bit.
- **`busy`.** Falls in the cycle after the last stop bit completes with the FIFO empty.
- **Combinational paths.** None from inputs to outputs. `tx_ready` does not depend on `tx_valid`.

## Structure
- **Shared header.** Add `mfp_uart_const.vh` holding:
  - the state encodings (`MFP_UART_IDLE`, `_START`, `_DATA`, `_STOP`, 2 bits);
  - the default `CLK_HZ` and `BAUD` values;
  - the frame length (10 bits).
- **Sharing with the receiver.** The RX side includes the same header so both ends agree on baud and frame format.
- **Sub-module.** One: `mfp_uart_tx_fifo`, a synchronous FIFO with push/pop/count/full/empty, asynchronous active-high reset, and a power-of-2 pointer wrap. The FSM, baud counter and shift register stay in `mfp_uart_tx`.

## Test plan
Use `CLK_HZ`=1000 and `BAUD`=100 (`DIV`=10), `FIFO_DEPTH`=4.
1. **Single byte.** Push 0x55 while idle → `UART_TX` low from edge N+2 for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high for 10 cycles; `busy` then drops and `fifo_count` stays 0 after the pop.
2. **Burst with back-pressure.** Push 0x00, 0xFF, 0xA5, 0x3C, 0x81 on consecutive cycles.
   - 0x00 is popped; 0xFF, 0xA5, 0x3C, 0x81 fill the FIFO to count 4 and `tx_ready` goes low.
   - One extra push is refused while `tx_ready` is low.
   - All five frames leave with starts exactly 100 cycles apart and the data matches.
3. **Simultaneous push and pop.** Push on the final STOP cycle while the FIFO holds 1 byte → `fifo_count` stays 1, and the next START begins without a gap.
4. **Reset mid-frame.** Assert `HRESET` asynchronously during DATA bit 3 → `UART_TX`=1 before the next edge. After release, `fifo_count`=0, `busy`=0, `tx_ready`=1, and there are no further transitions.
5. **Baud rounding.** `CLK_HZ`=50_000_000, `BAUD`=115200 → measured bit period is 434 cycles and the 0xC3 frame spans 4340 cycles.

Source files
------------

// File: rtl/mfp_uart_tx_pkg.sv
// Shared UART constants: state encodings, default line settings and frame format.
// The receive side imports the same package so both ends agree on baud and framing.
package mfp_uart_tx_pkg;

  typedef enum logic [1:0] {
    MFP_UART_IDLE  = 2'd0,
    MFP_UART_START = 2'd1,
    MFP_UART_DATA  = 2'd2,
    MFP_UART_STOP  = 2'd3
  } mfp_uart_state_e;

  localparam int MFP_UART_CLK_HZ     = 50_000_000;
  localparam int MFP_UART_BAUD       = 115_200;
  localparam int MFP_UART_FRAME_BITS = 10;

  // Bit period in clocks, rounded to nearest.
  function automatic int mfp_uart_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; pointers wrap naturally on a power-of-2 depth.
module mfp_uart_tx_fifo
  import mfp_uart_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic                         push,
  input  logic                         pop,
  input  logic [7:0]                   wr_data,
  output logic [7:0]                   rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mfp_uart_tx.sv
// Buffered 8N1 UART transmitter: valid/ready byte input, FIFO, LSB-first serializer.
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for one bit period
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); may chain straight into the next START
module mfp_uart_tx
  import mfp_uart_tx_pkg::*;
#(
  parameter int CLK_HZ     = MFP_UART_CLK_HZ,
  parameter int BAUD       = MFP_UART_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              HCLK,
  input  logic                              HRESET,
  input  logic [7:0]                        tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              UART_TX,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int DIV = mfp_uart_div(CLK_HZ, BAUD);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] LAST = BW'(DIV - 1);

  mfp_uart_state_e state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      fifo_rd;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            tick;

  assign tick     = (baud_cnt == LAST);
  assign pop      = !fifo_empty &&
                    ((state == MFP_UART_IDLE) || (state == MFP_UART_STOP && tick));
  assign tx_ready = !fifo_full;
  assign busy     = (state != MFP_UART_IDLE) || !fifo_empty;

  mfp_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .push    (tx_valid),
    .pop     (pop),
    .wr_data (tx_data),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // UART_TX is registered from the current state, so the line lags the state by one cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= MFP_UART_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      UART_TX  <= 1'b1;
    end else begin
      baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
      case (state)
        MFP_UART_IDLE: begin
          UART_TX  <= 1'b1;
          baud_cnt <= '0;
          if (!fifo_empty) begin
            shift <= fifo_rd;
            state <= MFP_UART_START;
          end
        end
        MFP_UART_START: begin
          UART_TX <= 1'b0;
          if (tick) begin
            bit_idx <= '0;
            state   <= MFP_UART_DATA;
          end
        end
        MFP_UART_DATA: begin
          UART_TX <= shift[0];
          if (tick) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= MFP_UART_STOP;
          end
        end
        MFP_UART_STOP: begin
          UART_TX <= 1'b1;
          if (tick) begin
            if (!fifo_empty) begin
              shift <= fifo_rd;
              state <= MFP_UART_START;
            end else begin
              state <= MFP_UART_IDLE;
            end
          end
        end
        default: state <= MFP_UART_IDLE;
      endcase
    end
  end

endmodule
